id_hazard_ctrl: RTL and testbench
=================================

# id_hazard_ctrl

Hazard and stall sequencer for the decode stage of the 5-stage MIPS pipeline. It detects load-use and branch-operand hazards against the instructions in EX, MEM and WB. It drives the ID-stage bubble mux (`HazZero`), the PC and IF/ID write enables, the branch-comparator forwarding selects (`ForBranchA/B`) and a gated `IF_Flush`. A small FSM enforces the two-cycle stall a branch needs behind a load, and saturating counters expose stall statistics.

## Interface
- `CNT_W`, default 16: width of the statistics counters.
- `Clock` in 1: pipeline clock; all state changes on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `ID_RsReg`, `ID_RtReg` in 5 each: source registers of the instruction in ID.
- `ID_UsesRt` in 1: the instruction in ID reads Rt (R-type, beq, bne, sw).
- `Branch` in 1: the instruction in ID is beq, bne or jr; its operands are compared or used in ID.
- `IF_Flush` in 1: raw flush request from the control unit (taken branch or jump).
- `EX_RegWrite`, `EX_MemRead` in 1 each; `EX_DestReg` in 5: destination after the RegDst mux.
- `MEM_RegWrite`, `MEM_MemRead` in 1 each; `MEM_DestReg` in 5.
- `WB_RegWrite` in 1; `WB_DestReg` in 5.
- `HazZero` out 1: inserts a bubble into ID/EX.
- `PCWrite` out 1: PC update enable.
- `IFIDWrite` out 1: IF/ID register write enable.
- `IF_FlushOut` out 1: flush gated by the stall.
- `ForBranchA`, `ForBranchB` out 2 each: 00 = register file, 01 = WB_WriteData, 10 = MEM_ALUOut. Code 11 is never driven.
- `StallCycles` out CNT_W: total stalled cycles.
- `BranchStalls` out CNT_W: stalled cycles caused by branch operands.

## Operation
- A match against stage X means `X_RegWrite & (X_DestReg != 0) & (X_DestReg == ID_RsReg | (ID_UsesRt & X_DestReg == ID_RtReg))`.
- Stall length L is computed in state RUN only:
  - L = 2 if `Branch`, an EX match, and `EX_MemRead` are all true.
  - Else L = 1 if any of these hold: `Branch` & EX match (ALU producer); `Branch` & MEM match & `MEM_MemRead`; non-branch & EX match & `EX_MemRead` (load-use).
  - Else L = 0.
- FSM has two states: RUN and HOLD.
  - RUN with L = 0: no stall.
  - RUN with L = 1: stall this cycle, then stay in RUN and re-evaluate.
  - RUN with L = 2: stall this cycle and go to HOLD.
  - HOLD: stall unconditionally, then return to RUN.
- Stall outputs: `HazZero = 1`, `PCWrite = 0`, `IFIDWrite = 0`, `IF_FlushOut = 0`.
- Non-stall outputs: `HazZero = 0`, `PCWrite = 1`, `IFIDWrite = 1`, `IF_FlushOut = IF_Flush`.
- Forwarding is independent of the FSM; it is evaluated per operand with MEM taking priority over WB:
  - 10 if `MEM_RegWrite & !MEM_MemRead & MEM_DestReg != 0 & MEM_DestReg == reg`.
  - Else 01 if `WB_RegWrite & WB_DestReg != 0 & WB_DestReg == reg`.
  - Else 00.
- Counters:
  - `StallCycles` increments on every stalled cycle.
  - `BranchStalls` increments when a stalled cycle is in HOLD or was caused by `Branch`.
  - Both saturate at all-ones and never wrap.

## Timing
- Stall and forwarding outputs are combinational from the current state and inputs, valid in the same cycle as detection. There is no added latency.
- FSM state and counters are registered on the rising edge of `Clock`.
- Reset asserted (low), asynchronously: state = RUN, both counters = 0. Outputs then read as the non-stall values: `HazZero = 0`, `PCWrite = 1`, `IFIDWrite = 1`, `ForBranch* = 00`, `IF_FlushOut = IF_Flush`.
- Reset asserted while in HOLD aborts the remaining stall. The first cycle after release is evaluated fresh in RUN.
- In HOLD, the hazard inputs are ignored, including any new hazard.
- `IF_Flush` together with a stall: the flush is suppressed. The branch resolves after the stall, when the control unit re-asserts `IF_Flush`.
- Register $0 never matches, never stalls, and never forwards.
- EX and MEM matches together: the stall decision (L) takes precedence. Forwarding still selects MEM over WB.

## Structure
- Shared package `pipeline_pkg` holds:
  - forwarding codes `FWD_RF = 2'b00`, `FWD_WB = 2'b01`, `FWD_MEM = 2'b10`;
  - FSM state encoding `ST_RUN`, `ST_HOLD`.
- One sub-module, `sat_counter` (parameter W, inputs `inc`, `Clock`, `Reset`), instantiated twice for the two statistics counters.
- The hazard-match logic stays inline.

## Test plan
- Load-use: EX lw to $8 (`EX_MemRead = 1`), ID add reading $8 → one cycle with `HazZero = 1`, `PCWrite = 0`; next cycle no stall; `StallCycles = 1`, `BranchStalls = 0`.
- Branch after load: EX lw $9, ID beq $9,$0 → two consecutive stalled cycles (RUN then HOLD) even if EX inputs change in the second cycle; `BranchStalls = 2`.
- Branch after ALU op: EX add $10, ID bne $10,$3 → one stall. Next cycle with MEM add $10: `ForBranchA = 10`, no stall.
- WB forwarding and $0: WB writes $5, ID beq $5,$5 → `ForBranchA = ForBranchB = 01`. The same with dest $0 → `00`, no stall.
- Flush gating: `IF_Flush = 1` during a branch stall → `IF_FlushOut = 0`. With no stall → `IF_FlushOut = 1`.
- Reset low asserted mid-HOLD → immediately `HazZero = 0`, counters 0. Separately, force 2^CNT_W + 3 stalls → counter holds at 0xFFFF for CNT_W = 16.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared constants for the decode-stage hazard logic: branch-comparator
// forwarding codes, hazard FSM state encoding and the forwarding-select helper.
package pipeline_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Picks the source for one branch-comparator operand. MEM wins over WB.
    // A load in MEM has no data yet, so it is never a forwarding source.
    function automatic logic [1:0] fwd_select(
        input logic       mem_reg_write,
        input logic       mem_mem_read,
        input logic [4:0] mem_dest,
        input logic       wb_reg_write,
        input logic [4:0] wb_dest,
        input logic [4:0] src
    );
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem_reg_write && !mem_mem_read && (mem_dest != 5'd0) && (mem_dest == src)) begin
            sel = FWD_MEM;
        end else if (wb_reg_write && (wb_dest != 5'd0) && (wb_dest == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: advance on inc unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != MAX)) begin
            count_d = count_q + ONE;
        end
    end

    // Count register, cleared by the active-low asynchronous reset.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage hazard detector and stall sequencer for the 5-stage MIPS pipe.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_RUN  | normal issue; hazards evaluated, stall of 0/1/2 cycles
//   ST_HOLD | second stall cycle of a branch behind a load; inputs ignored
module id_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [4:0]       ID_RsReg,
    input  logic [4:0]       ID_RtReg,
    input  logic             ID_UsesRt,
    input  logic             Branch,
    input  logic             IF_Flush,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_DestReg,
    input  logic             MEM_RegWrite,
    input  logic             MEM_MemRead,
    input  logic [4:0]       MEM_DestReg,
    input  logic             WB_RegWrite,
    input  logic [4:0]       WB_DestReg,
    output logic             HazZero,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IF_FlushOut,
    output logic [1:0]       ForBranchA,
    output logic [1:0]       ForBranchB,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] BranchStalls
);

    logic [0:0] state_q;
    logic [0:0] state_d;
    logic       ex_match;
    logic       mem_match;
    logic       stall_two;
    logic       stall_one;
    logic       stall;
    logic       branch_stall;

    // Source-register matches against EX and MEM; $0 never matches.
    always_comb begin
        ex_match  = EX_RegWrite && (EX_DestReg != 5'd0) &&
                    ((EX_DestReg == ID_RsReg) || (ID_UsesRt && (EX_DestReg == ID_RtReg)));
        mem_match = MEM_RegWrite && (MEM_DestReg != 5'd0) &&
                    ((MEM_DestReg == ID_RsReg) || (ID_UsesRt && (MEM_DestReg == ID_RtReg)));
    end

    // Stall length decision and FSM next state; HOLD stalls regardless of inputs.
    always_comb begin
        stall_two    = Branch && ex_match && EX_MemRead;
        stall_one    = (Branch && ex_match) ||
                       (Branch && mem_match && MEM_MemRead) ||
                       (!Branch && ex_match && EX_MemRead);
        stall        = 1'b0;
        branch_stall = 1'b0;
        state_d      = state_q;
        if (state_q == ST_HOLD) begin
            stall        = 1'b1;
            branch_stall = 1'b1;
            state_d      = ST_RUN;
        end else begin
            stall        = stall_two || stall_one;
            branch_stall = (stall_two || stall_one) && Branch;
            state_d      = stall_two ? ST_HOLD : ST_RUN;
        end
    end

    // Pipeline control outputs; a pending flush waits until the stall clears.
    always_comb begin
        HazZero     = stall;
        PCWrite     = !stall;
        IFIDWrite   = !stall;
        IF_FlushOut = IF_Flush && !stall;
        ForBranchA  = fwd_select(MEM_RegWrite, MEM_MemRead, MEM_DestReg,
                                 WB_RegWrite, WB_DestReg, ID_RsReg);
        ForBranchB  = fwd_select(MEM_RegWrite, MEM_MemRead, MEM_DestReg,
                                 WB_RegWrite, WB_DestReg, ID_RtReg);
    end

    // FSM state register; reset drops any remaining HOLD cycle.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .Clock (Clock),
        .Reset (Reset),
        .inc   (stall),
        .count (StallCycles)
    );

    sat_counter #(.W(CNT_W)) u_branch_cnt (
        .Clock (Clock),
        .Reset (Reset),
        .inc   (branch_stall),
        .count (BranchStalls)
    );

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: expected per-cycle outputs go through a
// scoreboard queue, counters are tracked by a small saturating model.
module tb_id_hazard_ctrl;

    localparam int CNT_W = 16;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             Clock = 1'b0;
    logic             Reset;
    logic [4:0]       ID_RsReg, ID_RtReg;
    logic             ID_UsesRt, Branch, IF_Flush;
    logic             EX_RegWrite, EX_MemRead;
    logic [4:0]       EX_DestReg;
    logic             MEM_RegWrite, MEM_MemRead;
    logic [4:0]       MEM_DestReg;
    logic             WB_RegWrite;
    logic [4:0]       WB_DestReg;
    logic             HazZero, PCWrite, IFIDWrite, IF_FlushOut;
    logic [1:0]       ForBranchA, ForBranchB;
    logic [CNT_W-1:0] StallCycles, BranchStalls;

    typedef struct {
        string      tag;
        logic       stall;
        logic       bstall;
        logic       flush_out;
        logic [1:0] fa;
        logic [1:0] fb;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   m_stall = 0;
    int   m_branch = 0;

    id_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .ID_RsReg     (ID_RsReg),
        .ID_RtReg     (ID_RtReg),
        .ID_UsesRt    (ID_UsesRt),
        .Branch       (Branch),
        .IF_Flush     (IF_Flush),
        .EX_RegWrite  (EX_RegWrite),
        .EX_MemRead   (EX_MemRead),
        .EX_DestReg   (EX_DestReg),
        .MEM_RegWrite (MEM_RegWrite),
        .MEM_MemRead  (MEM_MemRead),
        .MEM_DestReg  (MEM_DestReg),
        .WB_RegWrite  (WB_RegWrite),
        .WB_DestReg   (WB_DestReg),
        .HazZero      (HazZero),
        .PCWrite      (PCWrite),
        .IFIDWrite    (IFIDWrite),
        .IF_FlushOut  (IF_FlushOut),
        .ForBranchA   (ForBranchA),
        .ForBranchB   (ForBranchB),
        .StallCycles  (StallCycles),
        .BranchStalls (BranchStalls)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        ID_RsReg = 5'd0; ID_RtReg = 5'd0; ID_UsesRt = 1'b0; Branch = 1'b0; IF_Flush = 1'b0;
        EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_DestReg = 5'd0;
        MEM_RegWrite = 1'b0; MEM_MemRead = 1'b0; MEM_DestReg = 5'd0;
        WB_RegWrite = 1'b0; WB_DestReg = 5'd0;
    endtask

    // Called at a falling edge after inputs are set: checks outputs, lets one
    // rising edge pass, checks counters, and returns at the next falling edge.
    task automatic cycle(input string tag, input logic stall, input logic bstall,
                         input logic flush_out, input logic [1:0] fa, input logic [1:0] fb);
        exp_t e;
        e.tag = tag; e.stall = stall; e.bstall = bstall;
        e.flush_out = flush_out; e.fa = fa; e.fb = fb;
        sb.push_back(e);
        #2;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.tag, "_HazZero"},     32'(HazZero),     32'(e.stall));
            chk({e.tag, "_PCWrite"},     32'(PCWrite),     32'(!e.stall));
            chk({e.tag, "_IFIDWrite"},   32'(IFIDWrite),   32'(!e.stall));
            chk({e.tag, "_IF_FlushOut"}, 32'(IF_FlushOut), 32'(e.flush_out));
            chk({e.tag, "_ForBranchA"},  32'(ForBranchA),  32'(e.fa));
            chk({e.tag, "_ForBranchB"},  32'(ForBranchB),  32'(e.fb));
            @(posedge Clock);
            if (Reset) begin
                if (e.stall && m_stall < CMAX) m_stall++;
                if (e.bstall && m_branch < CMAX) m_branch++;
            end
            #1;
            chk({e.tag, "_StallCycles"},  32'(StallCycles),  32'(m_stall));
            chk({e.tag, "_BranchStalls"}, 32'(BranchStalls), 32'(m_branch));
        end
        @(negedge Clock);
    endtask

    initial begin
        clear_inputs();
        Reset = 1'b0;
        IF_Flush = 1'b1;
        cycle("reset", 1'b0, 1'b0, 1'b1, 2'b00, 2'b00);
        Reset = 1'b1;

        // Load-use: lw $8 in EX, add reading $8 in ID.
        clear_inputs();
        EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_DestReg = 5'd8; ID_RsReg = 5'd8;
        cycle("loaduse", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);
        clear_inputs();
        MEM_RegWrite = 1'b1; MEM_MemRead = 1'b1; MEM_DestReg = 5'd8; ID_RsReg = 5'd8;
        cycle("loaduse_next", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

        // Branch behind a load: RUN stall, then HOLD stall ignoring inputs.
        clear_inputs();
        EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_DestReg = 5'd9;
        ID_RsReg = 5'd9; ID_UsesRt = 1'b1; Branch = 1'b1;
        cycle("brload_run", 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        EX_RegWrite = 1'b0; EX_MemRead = 1'b0; EX_DestReg = 5'd0;
        MEM_RegWrite = 1'b1; MEM_MemRead = 1'b1; MEM_DestReg = 5'd9;
        cycle("brload_hold", 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        MEM_RegWrite = 1'b0; MEM_MemRead = 1'b0; MEM_DestReg = 5'd0;
        WB_RegWrite = 1'b1; WB_DestReg = 5'd9; IF_Flush = 1'b1;
        cycle("brload_resolve", 1'b0, 1'b0, 1'b1, 2'b01, 2'b00);

        // Branch behind an ALU op, flush held off during the stall.
        clear_inputs();
        EX_RegWrite = 1'b1; EX_DestReg = 5'd10;
        ID_RsReg = 5'd10; ID_RtReg = 5'd3; ID_UsesRt = 1'b1; Branch = 1'b1; IF_Flush = 1'b1;
        cycle("bralu_stall", 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        EX_RegWrite = 1'b0; EX_DestReg = 5'd0;
        MEM_RegWrite = 1'b1; MEM_DestReg = 5'd10;
        cycle("bralu_fwd_mem", 1'b0, 1'b0, 1'b1, 2'b10, 2'b00);

        // WB forwarding on both operands, then the same with $0.
        clear_inputs();
        WB_RegWrite = 1'b1; WB_DestReg = 5'd5;
        ID_RsReg = 5'd5; ID_RtReg = 5'd5; ID_UsesRt = 1'b1; Branch = 1'b1;
        cycle("wb_fwd", 1'b0, 1'b0, 1'b0, 2'b01, 2'b01);
        WB_DestReg = 5'd0; ID_RsReg = 5'd0; ID_RtReg = 5'd0;
        cycle("wb_zero", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_DestReg = 5'd0;
        cycle("ex_load_zero", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

        // MEM beats WB for the same register; Rt forwarded independently.
        clear_inputs();
        MEM_RegWrite = 1'b1; MEM_DestReg = 5'd4; WB_RegWrite = 1'b1; WB_DestReg = 5'd4;
        ID_RsReg = 5'd4; ID_RtReg = 5'd7;
        cycle("mem_over_wb", 1'b0, 1'b0, 1'b0, 2'b10, 2'b00);

        // Rt only counts when the ID instruction reads it.
        clear_inputs();
        EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_DestReg = 5'd7;
        ID_RsReg = 5'd1; ID_RtReg = 5'd7;
        cycle("rt_unused", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
        ID_UsesRt = 1'b1;
        cycle("rt_used", 1'b1, 1'b0, 1'b0, 2'b00, 2'b00);

        // Branch behind a load in MEM: single stall, stays in RUN.
        clear_inputs();
        MEM_RegWrite = 1'b1; MEM_MemRead = 1'b1; MEM_DestReg = 5'd6;
        ID_RsReg = 5'd6; Branch = 1'b1;
        cycle("br_memload", 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        clear_inputs();
        cycle("br_memload_after", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

        // Reset during HOLD cancels the remaining stall at once.
        clear_inputs();
        EX_RegWrite = 1'b1; EX_MemRead = 1'b1; EX_DestReg = 5'd12;
        ID_RsReg = 5'd12; Branch = 1'b1;
        cycle("rsthold_run", 1'b1, 1'b1, 1'b0, 2'b00, 2'b00);
        clear_inputs();
        #2;
        chk("rsthold_in_hold", 32'(HazZero), 32'd1);
        Reset = 1'b0;
        #1;
        m_stall = 0;
        m_branch = 0;
        chk("rsthold_HazZero", 32'(HazZero), 32'd0);
        chk("rsthold_PCWrite", 32'(PCWrite), 32'd1);
        chk("rsthold_StallCycles", 32'(StallCycles), 32'd0);
        chk("rsthold_BranchStalls", 32'(BranchStalls), 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        cycle("rsthold_fresh", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);

        // Saturation: stall on every cycle well past 2^CNT_W.
        clear_inputs();
        EX_RegWrite = 1'b1; EX_DestReg = 5'd2; ID_RsReg = 5'd2; Branch = 1'b1;
        repeat (CMAX - 1) @(posedge Clock);
        #1;
        chk("sat_before_StallCycles", 32'(StallCycles), 32'(CMAX - 1));
        chk("sat_before_BranchStalls", 32'(BranchStalls), 32'(CMAX - 1));
        repeat (5) @(posedge Clock);
        #1;
        chk("sat_StallCycles", 32'(StallCycles), 32'(CMAX));
        chk("sat_BranchStalls", 32'(BranchStalls), 32'(CMAX));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
